// File: rtl/pingpong_unbuffer_pkg.sv
// Shared constants for the row serializer and the row-parallel stages around it.
package pingpong_unbuffer_pkg;

   localparam int ROW_LEN = 8;
   localparam int IDX_W   = 3;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROW_LEN - 1);

   // Source of a shifter load on an edge where the shifter is free.
   typedef enum logic [1:0] {
      LOAD_NONE = 2'd0,
      LOAD_HOLD = 2'd1,
      LOAD_IN   = 2'd2
   } load_sel_e;

endpackage

// File: rtl/pingpong_unbuffer_vdffe.sv
// Enable flip-flop with synchronous active-low clear, used for every buffered word.
module vdffe #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk) begin
      if (!rst) begin
         q <= '0;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/pingpong_unbuffer.sv
// Row serializer: accepts an 8-pixel row in one cycle, emits pixel 0 first,
// double-buffered by a holding register in front of the shift register.
module pingpong_unbuffer
   import pingpong_unbuffer_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [ROW_LEN-1:0][WIDTH-1:0]   in,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [WIDTH-1:0]                out,
   output logic                            out_last
);

   // Handshake: a transfer happens on a rising edge where valid && ready.
   // in_ready is pure register state (!hold_full), so there is no
   // combinational path from out_ready to in_ready; out_valid/out/out_last
   // stay stable while out_valid=1 and out_ready=0.

   logic                          busy;
   logic                          hold_full;
   logic [IDX_W-1:0]              idx;
   logic [ROW_LEN-1:0][WIDTH-1:0] shreg;
   logic [ROW_LEN-1:0][WIDTH-1:0] hold;
   logic [ROW_LEN-1:0][WIDTH-1:0] sh_d;

   logic      acc;
   logic      pop;
   logic      last_pop;
   logic      free;
   logic      hold_we;
   logic      sh_en;
   load_sel_e load_sel;

   assign acc      = in_valid && in_ready;
   assign pop      = out_valid && out_ready;
   assign last_pop = pop && (idx == LAST_IDX);
   // The shifter is empty after this edge unless something is loaded into it.
   assign free     = !busy || last_pop;

   always_comb begin
      load_sel = LOAD_NONE;
      if (free) begin
         if (hold_full) begin
            load_sel = LOAD_HOLD;
         end else if (acc) begin
            load_sel = LOAD_IN;
         end
      end
   end

   // An accepted row that does not bypass straight into the shifter is parked.
   assign hold_we = acc && (load_sel != LOAD_IN);
   assign sh_en   = pop || (load_sel != LOAD_NONE);

   always_comb begin
      sh_d = {shreg[ROW_LEN-1], shreg[ROW_LEN-1:1]};
      case (load_sel)
         LOAD_HOLD: sh_d = hold;
         LOAD_IN:   sh_d = in;
         default:   sh_d = {shreg[ROW_LEN-1], shreg[ROW_LEN-1:1]};
      endcase
   end

   vdffe #(
      .WIDTH(ROW_LEN * WIDTH)
   ) u_hold (
      .clk (clk),
      .rst (rst),
      .en  (hold_we),
      .d   (in),
      .q   (hold)
   );

   for (genvar i = 0; i < ROW_LEN; i++) begin : g_shreg
      vdffe #(
         .WIDTH(WIDTH)
      ) u_elem (
         .clk (clk),
         .rst (rst),
         .en  (sh_en),
         .d   (sh_d[i]),
         .q   (shreg[i])
      );
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         busy      <= 1'b0;
         hold_full <= 1'b0;
         idx       <= '0;
      end else begin
         if (free) begin
            busy <= (load_sel != LOAD_NONE);
            idx  <= '0;
         end else if (pop) begin
            idx <= idx + 1'b1;
         end

         if (hold_we) begin
            hold_full <= 1'b1;
         end else if (load_sel == LOAD_HOLD) begin
            hold_full <= 1'b0;
         end
      end
   end

   assign out       = shreg[0];
   assign out_valid = busy;
   assign out_last  = busy && (idx == LAST_IDX);
   assign in_ready  = !hold_full;

endmodule

// File: tb/tb_pingpong_unbuffer.sv
// Bench for pingpong_unbuffer: a pixel-queue model predicts every output each cycle.
module tb_pingpong_unbuffer;

   localparam int WIDTH = 8;

   logic                  clk;
   logic                  rst;
   logic                  in_valid;
   logic                  in_ready;
   logic [7:0][WIDTH-1:0] in;
   logic                  out_valid;
   logic                  out_ready;
   logic [WIDTH-1:0]      out;
   logic                  out_last;

   int tests;
   int fails;
   bit chk_en;

   pingpong_unbuffer #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in        (in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .out_last  (out_last)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: the block is a FIFO of pixels holding at most two whole rows.
   // A row is taken whenever at most one row's worth of pixels is pending.
   logic [WIDTH-1:0] exp_q[$];
   int pop_cnt;
   int rows_acc;

   always @(posedge clk) begin
      int n;
      bit do_acc;
      bit do_pop;
      if (!rst) begin
         exp_q.delete();
         pop_cnt = 0;
      end else begin
         n      = exp_q.size();
         do_acc = in_valid && (n <= 8);
         do_pop = (n > 0) && out_ready;
         if (do_pop) begin
            void'(exp_q.pop_front());
            pop_cnt++;
         end
         if (do_acc) begin
            for (int k = 0; k < 8; k++) exp_q.push_back(in[k]);
            rows_acc++;
         end
      end
   end

   always @(negedge clk) begin
      int n;
      if (chk_en) begin
         n = exp_q.size();
         check("in_ready", in_ready, n <= 8);
         check("out_valid", out_valid, n > 0);
         if (n > 0) begin
            check("out", out, exp_q[0]);
            check("out_last", out_last, (n % 8) == 1);
            check("last_every_8th", out_last, (pop_cnt % 8) == 7);
         end else begin
            check("out_last_idle", out_last, 1'b0);
         end
      end
   end

   // driver tasks
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_row(input logic [7:0] base);
      for (int k = 0; k < 8; k++) in[k] = base + 8'(k);
   endtask

   task automatic drain();
      bit done;
      done      = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 200 && !done; c++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !out_valid) done = 1'b1;
         else step();
      end
      check("drain_done", done, 1'b1);
   endtask

   initial begin
      tests     = 0;
      fails     = 0;
      chk_en    = 1'b0;
      rows_acc  = 0;
      pop_cnt   = 0;
      rst       = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in        = '0;

      // 1: reset then idle
      step();
      step();
      rst    = 1'b1;
      chk_en = 1'b1;
      @(negedge clk);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_last", out_last, 1'b0);
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_out", out, 8'h00);

      // 2: single row, element k visible k cycles after the first
      out_ready = 1'b1;
      set_row(8'h00);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         check("single_out", out, 32'(k));
         check("single_last", out_last, k == 7);
         step();
      end
      @(negedge clk);
      check("single_idle", out_valid, 1'b0);

      // 3: back-to-back rows stream without a bubble
      set_row(8'h00);
      in_valid = 1'b1;
      step();
      @(negedge clk);
      check("b2b_first", out, 8'h00);
      check("b2b_ready_a", in_ready, 1'b1);
      set_row(8'h10);
      step();
      in_valid = 1'b0;
      for (int i = 1; i < 16; i++) begin
         @(negedge clk);
         check("b2b_out", out, (i < 8) ? 32'(i) : 32'(8'h10 + 8'(i - 8)));
         check("b2b_valid", out_valid, 1'b1);
         if (i == 1) check("b2b_hold_full", in_ready, 1'b0);
         if (i == 8) check("b2b_hold_freed", in_ready, 1'b1);
         step();
      end
      drain();

      // 4: backpressure while a second row waits and a third is refused
      out_ready = 1'b1;
      set_row(8'h20);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      step();
      out_ready = 1'b0;
      set_row(8'h30);
      in_valid = 1'b1;
      step();
      set_row(8'h70);
      for (int s = 0; s < 3; s++) begin
         @(negedge clk);
         check("stall_out", out, 8'h22);
         check("stall_valid", out_valid, 1'b1);
         check("stall_refuse", in_ready, 1'b0);
         step();
      end
      drain();

      // 5: random traffic, 200 rows
      begin
         int target;
         target = rows_acc + 200;
         for (int c = 0; c < 20000 && rows_acc < target; c++) begin
            in_valid = 1'($urandom_range(0, 1));
            for (int k = 0; k < 8; k++) in[k] = 8'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            step();
         end
         check("random_rows_done", rows_acc >= target, 1'b1);
      end
      drain();

      // 6: reset mid-row with the holding register full
      out_ready = 1'b1;
      set_row(8'h40);
      in_valid = 1'b1;
      step();
      set_row(8'h50);
      step();
      in_valid = 1'b0;
      step();
      step();
      step();
      @(negedge clk);
      check("pre_rst_out", out, 8'h44);
      check("pre_rst_hold", in_ready, 1'b0);
      rst = 1'b0;
      step();
      @(negedge clk);
      check("mid_rst_valid", out_valid, 1'b0);
      check("mid_rst_ready", in_ready, 1'b1);
      check("mid_rst_out", out, 8'h00);
      rst = 1'b1;
      set_row(8'h60);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      @(negedge clk);
      check("post_rst_out", out, 8'h60);
      check("post_rst_valid", out_valid, 1'b1);
      drain();

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
